// File: rtl/counter_timer_pkg.sv
// Shared encodings for the multi-channel down-counter/timer peripheral:
// register offsets, CTRL bit positions, mode codes and channel FSM states.
package counter_timer_pkg;

   // Register offsets within a channel's 4-word window
   localparam logic [1:0] REG_LOAD   = 2'd0;
   localparam logic [1:0] REG_CTRL   = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;  // read-only
   localparam logic [1:0] REG_STATUS = 2'd3;  // bit0 pending, write-1-to-clear

   // CTRL register layout; bits above CTRL_W-1 are not stored and read as 0
   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IRQ_EN  = 3;
   localparam int CTRL_SRC     = 4;  // 1 = count every clk, 0 = count tick_in rises
   localparam int CTRL_W       = 5;

   // Mode codes; 2'b11 is reserved and behaves as one-shot
   localparam logic [1:0] MODE_ONESHOT  = 2'b00;
   localparam logic [1:0] MODE_PERIODIC = 2'b01;
   localparam logic [1:0] MODE_SQUARE   = 2'b10;

   // Per-channel FSM state
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,  // disabled, COUNT frozen, output low
      ST_RUN  = 2'd1,  // counting down on each effective tick
      ST_DONE = 2'd2   // one-shot expired, output held high
   } state_e;

   // Channel-index width, never narrower than one bit
   function automatic int ch_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/counter_timer_x_if.sv
// Register bus between the CPU side and the timer peripheral.
// Handshake: bus_we is a one-clk write strobe qualified by bus_addr/bus_wdata
// in the same cycle; there is no back-pressure, every strobed write is taken.
// bus_rdata is a purely combinational view of the register at bus_addr.
interface counter_timer_x_if #(
   parameter int AW = 4,
   parameter int DW = 32
) ();
   logic          bus_we;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic [DW-1:0] bus_rdata;

   modport master (output bus_we, output bus_addr, output bus_wdata, input bus_rdata);
   modport slave  (input bus_we, input bus_addr, input bus_wdata, output bus_rdata);
endinterface

// File: rtl/counter_channel.sv
// One timer channel: tick synchroniser and edge detect, LOAD/CTRL/COUNT/STATUS
// registers and the IDLE/RUN/DONE control FSM.
module counter_channel
   import counter_timer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick_i,
   input  logic              we_load_i,
   input  logic              we_ctrl_i,
   input  logic              we_status_i,
   input  logic [WIDTH-1:0]  wdata_i,
   output logic [WIDTH-1:0]  load_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [WIDTH-1:0]  count_o,
   output logic              pending_o,
   output logic              out_o,
   output state_e            state_o
);

   logic              sync1_q, sync2_q, sync3_q;
   logic [WIDTH-1:0]  load_q, load_d;
   logic [WIDTH-1:0]  count_q, count_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              pending_q, pending_d;
   logic              out_q, out_d;
   state_e            state_q, state_d;
   logic              tick_raw, tick_eff, expire;
   logic [1:0]        mode;

   // Two-flop synchroniser plus one history flop for rising-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= tick_i;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   // LOAD/CTRL writes win over a coincident tick; STATUS writes do not, so a
   // clear can race an expiry and lose
   assign tick_raw = ctrl_q[CTRL_SRC] ? 1'b1 : (sync2_q & ~sync3_q);
   assign tick_eff = tick_raw & ~we_load_i & ~we_ctrl_i;
   assign mode     = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];
   assign expire   = (state_q == ST_RUN) && tick_eff && (count_q == WIDTH'(1));

   // Next-state logic: register writes first, then counting in RUN
   always_comb begin
      load_d    = load_q;
      count_d   = count_q;
      ctrl_d    = ctrl_q;
      pending_d = pending_q;
      out_d     = out_q;
      state_d   = state_q;
      if (we_load_i) begin
         load_d  = wdata_i;
         count_d = wdata_i;
         out_d   = 1'b0;
         if (ctrl_q[CTRL_EN]) state_d = ST_RUN;
      end else if (we_ctrl_i) begin
         ctrl_d = wdata_i[CTRL_W-1:0];
         if (!wdata_i[CTRL_EN]) begin
            state_d = ST_IDLE;
            out_d   = 1'b0;
         end else if ((state_q == ST_IDLE) && (count_q != '0)) begin
            state_d = ST_RUN;
         end
      end else if (state_q == ST_RUN) begin
         // periodic output is a single-clk pulse
         if (mode == MODE_PERIODIC) out_d = 1'b0;
         if (expire) begin
            case (mode)
               MODE_PERIODIC: begin
                  count_d = load_q;
                  out_d   = 1'b1;
               end
               MODE_SQUARE: begin
                  count_d = load_q;
                  out_d   = ~out_q;
               end
               default: begin  // one-shot and reserved
                  count_d = '0;
                  out_d   = 1'b1;
                  state_d = ST_DONE;
               end
            endcase
         end else if (tick_eff && (count_q > WIDTH'(1))) begin
            count_d = count_q - WIDTH'(1);
         end
      end
      if (we_status_i && wdata_i[0]) pending_d = 1'b0;
      if (expire) pending_d = 1'b1;
   end

   // Channel register bank and FSM state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_q    <= '0;
         count_q   <= '0;
         ctrl_q    <= '0;
         pending_q <= 1'b0;
         out_q     <= 1'b0;
         state_q   <= ST_IDLE;
      end else begin
         load_q    <= load_d;
         count_q   <= count_d;
         ctrl_q    <= ctrl_d;
         pending_q <= pending_d;
         out_q     <= out_d;
         state_q   <= state_d;
      end
   end

   assign load_o    = load_q;
   assign ctrl_o    = ctrl_q;
   assign count_o   = count_q;
   assign pending_o = pending_q;
   assign out_o     = out_q;
   assign state_o   = state_q;

endmodule

// File: rtl/counter_timer_x.sv
// Multi-channel down-counter/timer: address decode, read mux and the
// registered OR-ed interrupt. dbg_state_o packs each channel's FSM state
// (2 bits per channel, channel 0 in the low bits).
module counter_timer_x
   import counter_timer_pkg::*;
#(
   parameter int CHANNELS = 3,
   parameter int WIDTH    = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   counter_timer_x_if.slave        bus,
   input  logic [CHANNELS-1:0]     tick_in,
   output logic [CHANNELS-1:0]     counter_OUT,
   output logic                    irq,
   output logic [2*CHANNELS-1:0]   dbg_state_o
);

   localparam int CH_W = ch_width(CHANNELS);

   logic [CH_W-1:0]   ch_idx;
   logic [1:0]        reg_idx;
   logic [WIDTH-1:0]  load_a  [CHANNELS];
   logic [WIDTH-1:0]  count_a [CHANNELS];
   logic [CTRL_W-1:0] ctrl_a  [CHANNELS];
   state_e            state_a [CHANNELS];
   logic [CHANNELS-1:0] pending_v, irq_req;
   logic [WIDTH-1:0]  rdata;
   logic              irq_q;

   assign ch_idx  = bus.bus_addr[CH_W+1:2];
   assign reg_idx = bus.bus_addr[1:0];

   // Channel indices at or above CHANNELS match no instance, so such writes drop
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic hit;
      assign hit = bus.bus_we && (ch_idx == CH_W'(i));

      counter_channel #(.WIDTH(WIDTH)) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .tick_i      (tick_in[i]),
         .we_load_i   (hit && (reg_idx == REG_LOAD)),
         .we_ctrl_i   (hit && (reg_idx == REG_CTRL)),
         .we_status_i (hit && (reg_idx == REG_STATUS)),
         .wdata_i     (bus.bus_wdata),
         .load_o      (load_a[i]),
         .ctrl_o      (ctrl_a[i]),
         .count_o     (count_a[i]),
         .pending_o   (pending_v[i]),
         .out_o       (counter_OUT[i]),
         .state_o     (state_a[i])
      );

      assign irq_req[i]            = pending_v[i] & ctrl_a[i][CTRL_IRQ_EN];
      assign dbg_state_o[2*i +: 2] = state_a[i];
   end

   // Combinational read of the addressed register; unmapped channels read 0
   always_comb begin
      rdata = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (ch_idx == CH_W'(i)) begin
            case (reg_idx)
               REG_LOAD:  rdata = load_a[i];
               REG_CTRL:  rdata = WIDTH'(ctrl_a[i]);
               REG_COUNT: rdata = count_a[i];
               default:   rdata = WIDTH'(pending_v[i]);
            endcase
         end
      end
   end

   assign bus.bus_rdata = rdata;

   // Interrupt is registered: follows pending & irq_en one clk later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) irq_q <= 1'b0;
      else        irq_q <= |irq_req;
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_counter_timer_x.sv
// Directed bench for counter_timer_x with three 32-bit channels.
module tb_counter_timer_x;
   import counter_timer_pkg::*;

   localparam int CHANNELS = 3;
   localparam int WIDTH    = 32;
   localparam int AW       = 4;

   // ---------------- clock / reset ----------------
   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [CHANNELS-1:0]   tick_in = '0;
   logic [CHANNELS-1:0]   counter_OUT;
   logic                  irq;
   logic [2*CHANNELS-1:0] dbg_state;
   int                    total = 0;
   int                    bad = 0;
   logic [WIDTH-1:0]      rv;

   always #5 clk = ~clk;

   counter_timer_x_if #(.AW(AW), .DW(WIDTH)) bus_if ();

   counter_timer_x #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus_if),
      .tick_in     (tick_in),
      .counter_OUT (counter_OUT),
      .irq         (irq),
      .dbg_state_o (dbg_state)
   );

   // ---------------- driver tasks ----------------
   function automatic logic [AW-1:0] ad(input int ch, input logic [1:0] r);
      return {2'(ch), r};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int ch, input logic [1:0] r, input logic [WIDTH-1:0] d);
      bus_if.bus_we    = 1'b1;
      bus_if.bus_addr  = ad(ch, r);
      bus_if.bus_wdata = d;
      step();
      bus_if.bus_we    = 1'b0;
   endtask

   task automatic rd(input int ch, input logic [1:0] r, output logic [WIDTH-1:0] d);
      bus_if.bus_addr = ad(ch, r);
      #1;
      d = bus_if.bus_rdata;
   endtask

   // one rising edge on tick_in[ch]; returns two clks after the sampling edge
   task automatic rise(input int ch);
      tick_in[ch] = 1'b1;
      step();
      chk("pulse_cleared", 32'(counter_OUT[ch]), 32'd0);
      tick_in[ch] = 1'b0;
      step();
      step();
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic rd_chk(input string tag, input int ch, input logic [1:0] r,
                         input logic [31:0] exp);
      logic [WIDTH-1:0] d;
      rd(ch, r, d);
      chk(tag, d, exp);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- directed sequence ----------------
   initial begin
      bus_if.bus_we    = 1'b0;
      bus_if.bus_addr  = '0;
      bus_if.bus_wdata = '0;
      repeat (2) step();

      // reset state
      rd_chk("rst_load0", 0, REG_LOAD, 0);
      rd_chk("rst_ctrl0", 0, REG_CTRL, 0);
      rd_chk("rst_count0", 0, REG_COUNT, 0);
      rd_chk("rst_status0", 0, REG_STATUS, 0);
      chk("rst_out", 32'(counter_OUT), 0);
      chk("rst_irq", 32'(irq), 0);
      chk("rst_state", 32'(dbg_state), 0);
      rst_n = 1'b1;
      step();

      // ch0 one-shot, clk source, irq enabled
      wr(0, REG_LOAD, 3);
      wr(0, REG_CTRL, 32'h19);
      rd_chk("os_count3", 0, REG_COUNT, 3);
      chk("os_state_run", 32'(dbg_state[1:0]), 1);
      step();
      rd_chk("os_count2", 0, REG_COUNT, 2);
      step();
      rd_chk("os_count1", 0, REG_COUNT, 1);
      step();
      rd_chk("os_count0", 0, REG_COUNT, 0);
      chk("os_out_set", 32'(counter_OUT[0]), 1);
      chk("os_irq_not_yet", 32'(irq), 0);
      step();
      chk("os_irq_set", 32'(irq), 1);
      rd_chk("os_pending", 0, REG_STATUS, 1);
      chk("os_state_done", 32'(dbg_state[1:0]), 2);
      wr(0, REG_STATUS, 1);
      rd_chk("os_pending_clr", 0, REG_STATUS, 0);
      step();
      chk("os_irq_clr", 32'(irq), 0);
      repeat (2) step();
      rd_chk("os_count_hold", 0, REG_COUNT, 0);
      chk("os_out_hold", 32'(counter_OUT[0]), 1);

      // ch1 periodic, tick_in source, LOAD=4
      wr(1, REG_LOAD, 4);
      wr(1, REG_CTRL, 32'h03);
      rd_chk("per_count_init", 1, REG_COUNT, 4);
      for (int r = 1; r <= 12; r++) begin
         rise(1);
         rd_chk($sformatf("per_count_r%0d", r), 1, REG_COUNT,
                ((r % 4) == 0) ? 32'd4 : 32'(4 - (r % 4)));
         chk($sformatf("per_out_r%0d", r), 32'(counter_OUT[1]),
             ((r % 4) == 0) ? 32'd1 : 32'd0);
      end
      step();
      chk("per_out_one_clk", 32'(counter_OUT[1]), 0);
      rd_chk("per_pending", 1, REG_STATUS, 1);
      chk("per_irq_masked", 32'(irq), 0);

      // ch2 square wave, clk source, LOAD=2
      wr(2, REG_LOAD, 2);
      wr(2, REG_CTRL, 32'h15);
      chk("sq_out_c2", 32'(counter_OUT[2]), 0);
      step(); chk("sq_out_c3", 32'(counter_OUT[2]), 0);
      step(); chk("sq_out_c4", 32'(counter_OUT[2]), 1);
      step(); chk("sq_out_c5", 32'(counter_OUT[2]), 1);
      step(); chk("sq_out_c6", 32'(counter_OUT[2]), 0);
      step(); chk("sq_out_c7", 32'(counter_OUT[2]), 0);
      step(); chk("sq_out_c8", 32'(counter_OUT[2]), 1);
      wr(2, REG_CTRL, 0);
      chk("sq_off_out", 32'(counter_OUT[2]), 0);
      rd_chk("sq_off_count", 2, REG_COUNT, 2);
      repeat (2) step();
      rd_chk("sq_frozen", 2, REG_COUNT, 2);
      chk("sq_state_idle", 32'(dbg_state[5:4]), 0);

      // ch0: STATUS clear in the expiry cycle loses to the expiry
      wr(0, REG_LOAD, 2);
      chk("race_out_cleared", 32'(counter_OUT[0]), 0);
      step();
      rd_chk("race_count1", 0, REG_COUNT, 1);
      wr(0, REG_STATUS, 1);
      rd_chk("race_pending", 0, REG_STATUS, 1);
      rd_chk("race_count0", 0, REG_COUNT, 0);

      // ch0: LOAD write in a tick cycle takes the written value
      wr(0, REG_LOAD, 5);
      rd_chk("wt_load5", 0, REG_COUNT, 5);
      wr(0, REG_LOAD, 7);
      rd_chk("wt_load7", 0, REG_COUNT, 7);
      step();
      rd_chk("wt_count6", 0, REG_COUNT, 6);

      // bring ch1 to COUNT=2 while ch0 runs out
      rise(1);
      rise(1);
      repeat (3) step();
      rd_chk("pre_rst_ch1", 1, REG_COUNT, 2);
      chk("pre_rst_out0", 32'(counter_OUT[0]), 1);
      chk("pre_rst_irq", 32'(irq), 1);

      // asynchronous reset mid-cycle
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out", 32'(counter_OUT), 0);
      chk("arst_irq", 32'(irq), 0);
      rd_chk("arst_count1", 1, REG_COUNT, 0);
      rd_chk("arst_load1", 1, REG_LOAD, 0);
      rd_chk("arst_ctrl1", 1, REG_CTRL, 0);
      rd_chk("arst_status0", 0, REG_STATUS, 0);
      chk("arst_state", 32'(dbg_state), 0);
      repeat (2) step();
      rst_n = 1'b1;
      step();

      // unmapped channel, read-only COUNT, CTRL masking
      wr(0, REG_LOAD, 32'h66);
      wr(3, REG_LOAD, 32'h55);
      rd_chk("oor_ch0", 0, REG_LOAD, 32'h66);
      rd_chk("oor_ch1", 1, REG_LOAD, 0);
      rd_chk("oor_ch2", 2, REG_LOAD, 0);
      rd_chk("oor_read", 3, REG_LOAD, 0);
      wr(0, REG_COUNT, 9);
      rd_chk("ro_count", 0, REG_COUNT, 32'h66);
      wr(1, REG_CTRL, 32'hFFFF_FFF2);
      rd_chk("ctrl_mask", 1, REG_CTRL, 32'h12);
      chk("end_out", 32'(counter_OUT), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
